// File: rtl/out24_pkg.sv
// Shared types and constants for the out24 slice-collector slice.
package out24_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, MERGE, EMIT} state_t;

   localparam int unsigned ENTRY_W      = 18;
   localparam int unsigned SLICE_HI_DEF = 14;
   localparam int unsigned SLICE_LO_DEF = 8;

   // FIFO entry layout: control bit above the 17-bit bus word
   typedef struct packed {
      logic        sgn;
      logic [21:5] word;
   } entry_t;

endpackage

// File: rtl/out24_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full/empty decoded from the pointer pair.
module out24_sync_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ENTRY_W = 18
) (
   input  logic               clock_0,
   input  logic               reset_0,
   input  logic               push,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic               pop,
   output logic [ENTRY_W-1:0] rdata,
   output logic               full,
   output logic               empty
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   logic [PTR_W-1:0]   wptr_q, rptr_q;
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic               push_ok, pop_ok;

   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty   = (wptr_q == rptr_q);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rptr_q[AW-1:0]];

   always_ff @(posedge clock_0 or posedge reset_0) begin
      if (reset_0) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid
   always_ff @(posedge clock_0) begin
      if (push_ok) mem[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/out24_slice_collector.sv
// Buffers out24 bus words, rebuilds each through a load/slice-merge/emit FSM, and
// presents the result on a valid/ready port with a wrapping emit counter.
module out24_slice_collector
   import out24_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned SLICE_HI = SLICE_HI_DEF,
   parameter int unsigned SLICE_LO = SLICE_LO_DEF
) (
   input  logic               clock_0,
   input  logic               reset_0,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [21:5]        in24,
   input  logic signed [28:28] in1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [21:5]        out_data,
   output logic [7:0]         out_cnt
);

   localparam int unsigned SLICE_W = SLICE_HI - SLICE_LO + 1;

   state_t              state_q, state_d;
   logic [21:8]         acc_q, acc_d;
   logic [7:5]          tag_q, tag_d;
   logic                sgn_q, sgn_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                pop;
   logic                fifo_full, fifo_empty;
   logic [ENTRY_W-1:0]  fifo_rdata;
   entry_t              head;
   logic [SLICE_W-1:0]  merge_rhs;

   out24_sync_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clock_0 (clock_0),
      .reset_0 (reset_0),
      .push    (in_valid),
      .wdata   ({in1, in24}),
      .pop     (pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head      = entry_t'(fifo_rdata);
   assign in_ready  = ~fifo_full & ~reset_0;
   assign out_valid = (state_q == EMIT);
   assign out_data  = {acc_q, tag_q};
   assign out_cnt   = cnt_q;

   // 2-bit RHS is always 2'b11; it is zero-extended into the slice, never sign-extended
   assign merge_rhs = SLICE_W'({1'b1, ~(sgn_q & ~sgn_q)});

   always_ff @(posedge clock_0 or posedge reset_0) begin
      if (reset_0) begin
         state_q <= IDLE;
         acc_q   <= '0;
         tag_q   <= '0;
         sgn_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         tag_q   <= tag_d;
         sgn_q   <= sgn_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      tag_d   = tag_q;
      sgn_d   = sgn_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = LOAD;
         end
         LOAD: begin
            pop     = 1'b1;
            acc_d   = head.word[21:8];
            tag_d   = head.word[7:5];
            sgn_d   = head.sgn;
            state_d = MERGE;
         end
         MERGE: begin
            acc_d[SLICE_HI:SLICE_LO] = merge_rhs;
            state_d                  = EMIT;
         end
         EMIT: begin
            if (out_ready) begin
               cnt_d   = cnt_q + 8'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
